// File: rtl/ptp_pkg.sv
// Shared PTP receive definitions: flit framing codes, message types, field positions and FSM states.
package ptp_pkg;

   localparam int unsigned FLIT_W    = 134;
   localparam int unsigned PAYLOAD_W = 128;
   localparam int unsigned TS_W      = 48;
   localparam int unsigned PORT_W    = 6;
   localparam int unsigned MAC_W     = 48;
   localparam int unsigned KEY_W     = MAC_W + PORT_W;
   localparam int unsigned MSG_W     = 8;
   localparam int unsigned TYPE_W    = 4;
   localparam int unsigned CNT_W     = 32;

   localparam logic [15:0]       PTP_ETYPE     = 16'h88F7;
   localparam logic [MSG_W-1:0]  PTP_MSG_SYNC  = 8'h01;
   localparam logic [MSG_W-1:0]  PTP_MSG_REQ   = 8'h03;
   localparam logic [MSG_W-1:0]  PTP_MSG_RESP  = 8'h04;
   localparam logic [MAC_W-1:0]  MAC_BCAST     = 48'hFFFF_FFFF_FFFF;
   localparam logic [TYPE_W-1:0] RCV_TYPE_SYNC = 4'd1;
   localparam logic [TYPE_W-1:0] RCV_TYPE_RESP = 4'd4;

   // Bit positions inside the 128-bit flit payload
   localparam int unsigned META_PORT_LSB = 120;
   localparam int unsigned META_TS_LSB   = 0;
   localparam int unsigned TAIL_TS_LSB   = 48;

   typedef enum logic [1:0] {
      FLIT_NONE = 2'b00,
      FLIT_HEAD = 2'b01,
      FLIT_TAIL = 2'b10,
      FLIT_MID  = 2'b11
   } flit_code_t;

   typedef struct packed {
      flit_code_t            code;
      logic [3:0]            vbyte;
      logic [PAYLOAD_W-1:0]  payload;
   } flit_t;

   typedef struct packed {
      logic [MAC_W-1:0] dst;
      logic [MAC_W-1:0] src;
      logic [15:0]      etype;
      logic [MSG_W-1:0] msgtype;
      logic [7:0]       rsvd;
   } eth_hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_META,
      ST_ETH,
      ST_BODY
   } rx_state_t;

endpackage

// File: rtl/ptp_rx_stats.sv
// Wrapping receive statistics counters for the PTP RX parser.
module ptp_rx_stats
   import ptp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sync_inc,
   input  logic             req_inc,
   input  logic             resp_inc,
   input  logic             drop_inc,
   output logic [CNT_W-1:0] rx_sync_cnt,
   output logic [CNT_W-1:0] rx_req_cnt,
   output logic [CNT_W-1:0] rx_resp_cnt,
   output logic [CNT_W-1:0] rx_drop_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_cnt <= '0;
         rx_req_cnt  <= '0;
         rx_resp_cnt <= '0;
         rx_drop_cnt <= '0;
      end else begin
         if (sync_inc) rx_sync_cnt <= rx_sync_cnt + CNT_W'(1);
         if (req_inc)  rx_req_cnt  <= rx_req_cnt  + CNT_W'(1);
         if (resp_inc) rx_resp_cnt <= rx_resp_cnt + CNT_W'(1);
         if (drop_inc) rx_drop_cnt <= rx_drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ptp_rx_parser.sv
// Receive-side PTP parser: extracts req keys/timestamps and sync/resp reports from the MAC RX flit stream.
// Define PTP_RX_STATS_EN to add the rx_*_cnt statistics outputs.
module ptp_rx_parser
   import ptp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_data_wr,
   input  logic [FLIT_W-1:0] in_data,
   input  logic              in_valid_wr,
   input  logic              in_valid,
   input  logic [MAC_W-1:0]  MAC_ADDR,
   output logic [KEY_W-1:0]  key,
   output logic              key_valid,
   output logic [TS_W-1:0]   ts_4,
   output logic              ts_4_valid,
   output logic [TYPE_W-1:0] ptp_rcv_type,
   output logic              ptp_rcv_valid,
   output logic [TS_W-1:0]   t_origin,
   output logic [TS_W-1:0]   t_rx
`ifdef PTP_RX_STATS_EN
   ,
   output logic [CNT_W-1:0]  rx_sync_cnt,
   output logic [CNT_W-1:0]  rx_req_cnt,
   output logic [CNT_W-1:0]  rx_resp_cnt,
   output logic [CNT_W-1:0]  rx_drop_cnt
`endif
);

   flit_t     flit;
   eth_hdr_t  hdr;
   rx_state_t state_q, state_d;

   logic              cap_meta, cap_eth, tail_eth, tail_short;
   logic              accept, is_sync, is_req, is_resp, is_drop;
   logic [PORT_W-1:0] port_q;
   logic [TS_W-1:0]   rx_ts_q;
   logic [MAC_W-1:0]  src_q;
   logic [MSG_W-1:0]  msg_q;
   logic              hit_q;

   assign flit = flit_t'(in_data);
   assign hdr  = eth_hdr_t'(flit.payload);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // A head always restarts parsing; mid/tail only advance an open packet
   always_comb begin
      state_d    = state_q;
      cap_meta   = 1'b0;
      cap_eth    = 1'b0;
      tail_eth   = 1'b0;
      tail_short = 1'b0;
      if (in_data_wr) begin
         if (flit.code == FLIT_HEAD) begin
            state_d  = ST_META;
            cap_meta = 1'b1;
         end else begin
            case (state_q)
               ST_META: begin
                  if (flit.code == FLIT_MID) begin
                     state_d = ST_ETH;
                     cap_eth = 1'b1;
                  end else if (flit.code == FLIT_TAIL) begin
                     state_d    = ST_IDLE;
                     tail_short = 1'b1;
                  end
               end
               ST_ETH, ST_BODY: begin
                  if (flit.code == FLIT_MID) begin
                     state_d = ST_BODY;
                  end else if (flit.code == FLIT_TAIL) begin
                     state_d  = ST_IDLE;
                     tail_eth = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
      accept  = tail_eth & in_valid_wr & in_valid & hit_q;
      is_sync = accept & (msg_q == PTP_MSG_SYNC);
      is_req  = accept & (msg_q == PTP_MSG_REQ);
      is_resp = accept & (msg_q == PTP_MSG_RESP);
      is_drop = tail_short | (tail_eth & ~(is_sync | is_req | is_resp));
   end

   // Per-packet context captured from the meta and Ethernet flits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         port_q  <= '0;
         rx_ts_q <= '0;
         src_q   <= '0;
         msg_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         if (cap_meta) begin
            port_q  <= flit.payload[META_PORT_LSB +: PORT_W];
            rx_ts_q <= flit.payload[META_TS_LSB +: TS_W];
         end
         if (cap_eth) begin
            src_q <= hdr.src;
            msg_q <= hdr.msgtype;
            hit_q <= (hdr.etype == PTP_ETYPE) && ((hdr.dst == MAC_ADDR) || (hdr.dst == MAC_BCAST));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key           <= '0;
         key_valid     <= 1'b0;
         ts_4          <= '0;
         ts_4_valid    <= 1'b0;
         ptp_rcv_type  <= '0;
         ptp_rcv_valid <= 1'b0;
         t_origin      <= '0;
         t_rx          <= '0;
      end else begin
         key_valid     <= is_req;
         ts_4_valid    <= is_req;
         ptp_rcv_valid <= is_sync | is_resp;
         if (is_req) begin
            key  <= {src_q, port_q};
            ts_4 <= rx_ts_q;
         end
         if (is_sync | is_resp) begin
            ptp_rcv_type <= is_sync ? RCV_TYPE_SYNC : RCV_TYPE_RESP;
            t_origin     <= flit.payload[TAIL_TS_LSB +: TS_W];
            t_rx         <= rx_ts_q;
         end
      end
   end

`ifdef PTP_RX_STATS_EN
   ptp_rx_stats u_stats (
      .clk         (clk),
      .rst_n       (rst_n),
      .sync_inc    (is_sync),
      .req_inc     (is_req),
      .resp_inc    (is_resp),
      .drop_inc    (is_drop),
      .rx_sync_cnt (rx_sync_cnt),
      .rx_req_cnt  (rx_req_cnt),
      .rx_resp_cnt (rx_resp_cnt),
      .rx_drop_cnt (rx_drop_cnt)
   );
   logic unused_bits;
   assign unused_bits = ^{flit.vbyte, hdr.rsvd};
`else
   logic unused_bits;
   assign unused_bits = ^{flit.vbyte, hdr.rsvd, is_drop};
`endif

endmodule

// File: tb/tb_ptp_rx_parser.sv
// Self-checking bench for ptp_rx_parser: directed scenarios plus randomized packets against a packet-level model.
module tb_ptp_rx_parser;

   localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_AA;
   localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_data_wr = 1'b0;
   logic [133:0] in_data = '0;
   logic         in_valid_wr = 1'b0;
   logic         in_valid = 1'b0;
   logic [47:0]  mac_addr = MY_MAC;
   logic [53:0]  key;
   logic         key_valid;
   logic [47:0]  ts_4;
   logic         ts_4_valid;
   logic [3:0]   ptp_rcv_type;
   logic         ptp_rcv_valid;
   logic [47:0]  t_origin;
   logic [47:0]  t_rx;
`ifdef PTP_RX_STATS_EN
   logic [31:0]  rx_sync_cnt, rx_req_cnt, rx_resp_cnt, rx_drop_cnt;
`endif

   ptp_rx_parser dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data_wr    (in_data_wr),
      .in_data       (in_data),
      .in_valid_wr   (in_valid_wr),
      .in_valid      (in_valid),
      .MAC_ADDR      (mac_addr),
      .key           (key),
      .key_valid     (key_valid),
      .ts_4          (ts_4),
      .ts_4_valid    (ts_4_valid),
      .ptp_rcv_type  (ptp_rcv_type),
      .ptp_rcv_valid (ptp_rcv_valid),
      .t_origin      (t_origin),
      .t_rx          (t_rx)
`ifdef PTP_RX_STATS_EN
      ,
      .rx_sync_cnt   (rx_sync_cnt),
      .rx_req_cnt    (rx_req_cnt),
      .rx_resp_cnt   (rx_resp_cnt),
      .rx_drop_cnt   (rx_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] etype;
      logic [7:0]  msg;
      logic [5:0]  port;
      logic [47:0] rx_ts;
      logic [47:0] tail_ts;
      logic        vwr;
      logic        v;
      int          n_mid;
      bit          short_pkt;
      bit          abort;
      int          gap;
   } pkt_t;

   typedef struct packed {
      logic [53:0] key;
      logic [47:0] ts;
      logic [31:0] cyc;
   } key_ev_t;

   typedef struct packed {
      logic [3:0]  typ;
      logic [47:0] torig;
      logic [47:0] trx;
      logic [31:0] cyc;
   } rcv_ev_t;

   key_ev_t key_obs[$], key_exp[$];
   rcv_ev_t rcv_obs[$], rcv_exp[$];

   int unsigned tests = 0, fails = 0, tsv_bad = 0;
   int unsigned m_sync = 0, m_req = 0, m_resp = 0, m_drop = 0;
   logic [53:0] last_key = '0;
   logic [47:0] last_ts4 = '0, last_torig = '0, last_trx = '0;
   logic [3:0]  last_type = '0;

   // Observe every pulse with the cycle it appeared in
   always @(negedge clk) begin
      if (rst_n) begin
         if (key_valid)     key_obs.push_back('{key: key, ts: ts_4, cyc: cyc});
         if (ptp_rcv_valid) rcv_obs.push_back('{typ: ptp_rcv_type, torig: t_origin, trx: t_rx, cyc: cyc});
         if (key_valid !== ts_4_valid) tsv_bad++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_data_wr  = 1'b0;
         in_valid_wr = 1'b0;
         in_data     = {2'($urandom), 4'($urandom), rnd128()};
      end
   endtask

   task automatic send_flit(input logic [1:0] code, input logic [127:0] pl, input logic vwr, input logic v);
      @(negedge clk);
      in_data_wr  = 1'b1;
      in_data     = {code, 4'($urandom), pl};
      in_valid_wr = vwr;
      in_valid    = v;
   endtask

   function automatic pkt_t base_pkt();
      pkt_t p;
      p.dst = MY_MAC;   p.src = 48'h02_00_00_00_00_11;
      p.etype = 16'h88F7; p.msg = 8'h03; p.port = 6'd3;
      p.rx_ts = 48'h1_0000_0100; p.tail_ts = 48'h0;
      p.vwr = 1'b1; p.v = 1'b1; p.n_mid = 1;
      p.short_pkt = 1'b0; p.abort = 1'b0; p.gap = 0;
      return p;
   endfunction

   function automatic pkt_t rnd_pkt();
      pkt_t p;
      int r;
      p = base_pkt();
      p.src = 48'({$urandom, $urandom});
      r = int'($urandom_range(9, 0));
      if (r < 6)      p.dst = mac_addr;
      else if (r < 8) p.dst = BCAST;
      else            p.dst = 48'({$urandom, $urandom});
      p.etype = ($urandom_range(7, 0) == 0) ? 16'h0800 : 16'h88F7;
      case ($urandom_range(5, 0))
         0:       p.msg = 8'h01;
         1, 3:    p.msg = 8'h03;
         2:       p.msg = 8'h04;
         4:       p.msg = 8'h02;
         default: p.msg = 8'h08;
      endcase
      p.port      = 6'($urandom);
      p.rx_ts     = 48'({$urandom, $urandom});
      p.tail_ts   = 48'({$urandom, $urandom});
      p.vwr       = ($urandom_range(9, 0) != 0);
      p.v         = ($urandom_range(9, 0) != 0);
      p.n_mid     = int'($urandom_range(3, 0));
      p.short_pkt = ($urandom_range(11, 0) == 0);
      p.abort     = ($urandom_range(11, 0) == 0);
      p.gap       = int'($urandom_range(1, 0));
      return p;
   endfunction

   // Drive one packet and record what the specification says it must produce
   task automatic send_pkt(input pkt_t p);
      logic [127:0] pl;
      bit acc;
      pl = rnd128();
      pl[125:120] = p.port;
      pl[47:0]    = p.rx_ts;
      send_flit(2'b01, pl, 1'b0, 1'b0);
      if (!p.short_pkt) begin
         idle(int'($urandom_range(p.gap, 0)));
         send_flit(2'b11, {p.dst, p.src, p.etype, p.msg, 8'($urandom)}, 1'b0, 1'b0);
         for (int i = 0; i < p.n_mid; i++) begin
            idle(int'($urandom_range(p.gap, 0)));
            send_flit(2'b11, rnd128(), 1'b0, 1'b0);
         end
      end
      if (p.abort) return;
      idle(int'($urandom_range(p.gap, 0)));
      pl = rnd128();
      pl[95:48] = p.tail_ts;
      send_flit(2'b10, pl, p.vwr, p.v);
      acc = p.vwr && p.v && !p.short_pkt && (p.etype == 16'h88F7) &&
            ((p.dst == mac_addr) || (p.dst == BCAST)) &&
            ((p.msg == 8'h01) || (p.msg == 8'h03) || (p.msg == 8'h04));
      if (acc && p.msg == 8'h03) begin
         last_key = {p.src, p.port};
         last_ts4 = p.rx_ts;
         key_exp.push_back('{key: last_key, ts: last_ts4, cyc: cyc + 1});
         m_req++;
      end else if (acc) begin
         last_type  = (p.msg == 8'h01) ? 4'd1 : 4'd4;
         last_torig = p.tail_ts;
         last_trx   = p.rx_ts;
         rcv_exp.push_back('{typ: last_type, torig: last_torig, trx: last_trx, cyc: cyc + 1});
         if (p.msg == 8'h01) m_sync++;
         else                m_resp++;
      end else begin
         m_drop++;
      end
   endtask

   task automatic check_events(input string tag);
      chk({tag, " key pulse count"}, 128'(key_obs.size()), 128'(key_exp.size()));
      for (int i = 0; i < key_exp.size() && i < key_obs.size(); i++) begin
         chk($sformatf("%s key[%0d]", tag, i), 128'(key_obs[i].key), 128'(key_exp[i].key));
         chk($sformatf("%s ts_4[%0d]", tag, i), 128'(key_obs[i].ts), 128'(key_exp[i].ts));
         chk($sformatf("%s key cycle[%0d]", tag, i), 128'(key_obs[i].cyc), 128'(key_exp[i].cyc));
      end
      chk({tag, " rcv pulse count"}, 128'(rcv_obs.size()), 128'(rcv_exp.size()));
      for (int i = 0; i < rcv_exp.size() && i < rcv_obs.size(); i++) begin
         chk($sformatf("%s rcv type[%0d]", tag, i), 128'(rcv_obs[i].typ), 128'(rcv_exp[i].typ));
         chk($sformatf("%s t_origin[%0d]", tag, i), 128'(rcv_obs[i].torig), 128'(rcv_exp[i].torig));
         chk($sformatf("%s t_rx[%0d]", tag, i), 128'(rcv_obs[i].trx), 128'(rcv_exp[i].trx));
         chk($sformatf("%s rcv cycle[%0d]", tag, i), 128'(rcv_obs[i].cyc), 128'(rcv_exp[i].cyc));
      end
      key_obs.delete(); key_exp.delete(); rcv_obs.delete(); rcv_exp.delete();
      chk({tag, " key hold"}, 128'(key), 128'(last_key));
      chk({tag, " ts_4 hold"}, 128'(ts_4), 128'(last_ts4));
      chk({tag, " type hold"}, 128'(ptp_rcv_type), 128'(last_type));
      chk({tag, " t_origin hold"}, 128'(t_origin), 128'(last_torig));
      chk({tag, " t_rx hold"}, 128'(t_rx), 128'(last_trx));
`ifdef PTP_RX_STATS_EN
      chk({tag, " sync cnt"}, 128'(rx_sync_cnt), 128'(m_sync));
      chk({tag, " req cnt"}, 128'(rx_req_cnt), 128'(m_req));
      chk({tag, " resp cnt"}, 128'(rx_resp_cnt), 128'(m_resp));
      chk({tag, " drop cnt"}, 128'(rx_drop_cnt), 128'(m_drop));
`endif
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " key"}, 128'(key), 128'(0));
      chk({tag, " key_valid"}, 128'(key_valid), 128'(0));
      chk({tag, " ts_4"}, 128'(ts_4), 128'(0));
      chk({tag, " ts_4_valid"}, 128'(ts_4_valid), 128'(0));
      chk({tag, " ptp_rcv_type"}, 128'(ptp_rcv_type), 128'(0));
      chk({tag, " ptp_rcv_valid"}, 128'(ptp_rcv_valid), 128'(0));
      chk({tag, " t_origin"}, 128'(t_origin), 128'(0));
      chk({tag, " t_rx"}, 128'(t_rx), 128'(0));
`ifdef PTP_RX_STATS_EN
      chk({tag, " stats"}, 128'({rx_sync_cnt, rx_req_cnt, rx_resp_cnt, rx_drop_cnt}), 128'(0));
`endif
   endtask

   task automatic model_reset();
      m_sync = 0; m_req = 0; m_resp = 0; m_drop = 0;
      last_key = '0; last_ts4 = '0; last_torig = '0; last_trx = '0; last_type = '0;
      key_obs.delete(); key_exp.delete(); rcv_obs.delete(); rcv_exp.delete();
   endtask

   initial begin
      pkt_t p;
      logic [127:0] pl;

      idle(3);
      rst_n = 1'b1;
      idle(1);
      check_zero("reset");

      // Directed req to this node
      p = base_pkt();
      send_pkt(p);
      idle(3);
      check_events("req");
      chk("req key value", 128'(key), 128'({48'h02_00_00_00_00_11, 6'd3}));
      chk("req ts_4 value", 128'(ts_4), 128'(48'h1_0000_0100));

      // Broadcast sync
      p = base_pkt();
      p.dst = BCAST; p.msg = 8'h01; p.n_mid = 2;
      p.rx_ts = 48'h5_0001_E900; p.tail_ts = 48'h5_0001_E848;
      send_pkt(p);
      idle(3);
      check_events("sync");
      chk("sync t_origin value", 128'(t_origin), 128'(48'h5_0001_E848));

      // Non-PTP ethertype, then a resp marked bad
      p = base_pkt();
      p.etype = 16'h0800;
      send_pkt(p);
      p = base_pkt();
      p.msg = 8'h04; p.v = 1'b0;
      send_pkt(p);
      idle(3);
      check_events("drops");
`ifdef PTP_RX_STATS_EN
      chk("drops two counted", 128'(rx_drop_cnt), 128'(2));
`endif

      // Second head before tail aborts the first packet
      p = base_pkt();
      p.src = 48'h02_00_00_00_0B_AD; p.abort = 1'b1; p.n_mid = 0;
      send_pkt(p);
      p = base_pkt();
      p.src = 48'h02_00_00_00_00_22; p.port = 6'd9; p.rx_ts = 48'h0_0000_2222;
      send_pkt(p);
      idle(3);
      check_events("abort");

      // Short packet (head then tail) and stray mid/tail while idle
      p = base_pkt();
      p.short_pkt = 1'b1;
      send_pkt(p);
      send_flit(2'b11, rnd128(), 1'b0, 1'b0);
      send_flit(2'b10, rnd128(), 1'b1, 1'b1);
      idle(3);
      check_events("short");

      // Back-to-back req, resp, req at one flit per cycle
      p = base_pkt();
      p.src = 48'h02_00_00_00_00_31; p.port = 6'd1; p.rx_ts = 48'h0_0000_0031; p.n_mid = 0;
      send_pkt(p);
      p.msg = 8'h04; p.src = 48'h02_00_00_00_00_32; p.rx_ts = 48'h0_0000_0032; p.tail_ts = 48'h7_0000_0032;
      send_pkt(p);
      p.msg = 8'h03; p.src = 48'h02_00_00_00_00_33; p.port = 6'd63; p.rx_ts = 48'h0_0000_0033;
      send_pkt(p);
      idle(3);
      check_events("b2b");

      // Reset in the body of a req
      p = base_pkt();
      pl = rnd128();
      pl[125:120] = p.port;
      pl[47:0] = p.rx_ts;
      send_flit(2'b01, pl, 1'b0, 1'b0);
      send_flit(2'b11, {p.dst, p.src, p.etype, p.msg, 8'h00}, 1'b0, 1'b0);
      send_flit(2'b11, rnd128(), 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      in_data = {2'b10, 4'h0, rnd128()};
      in_valid_wr = 1'b1;
      in_valid = 1'b1;
      idle(2);
      rst_n = 1'b1;
      model_reset();
      idle(1);
      check_zero("mid-packet reset");
      p = base_pkt();
      p.src = 48'h02_00_00_00_00_66; p.port = 6'd6; p.rx_ts = 48'h0_0006_0006;
      send_pkt(p);
      idle(3);
      check_events("after reset");

      // Randomized traffic
      for (int blk = 0; blk < 6; blk++) begin
         for (int n = 0; n < 15; n++) begin
            send_pkt(rnd_pkt());
            idle(int'($urandom_range(1, 0)));
         end
         idle(3);
         check_events($sformatf("random blk%0d", blk));
      end

      chk("ts_4_valid follows key_valid", 128'(tsv_bad), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
